bubble_sorter: RTL and testbench

- Sorts, in place and ascending, an N-entry unsigned array held in an internal RAM, using a sequential bubble-sort FSM.
- Software or the bench preloads the RAM hierarchically and pulses or holds `start`; the block raises `complete` when the array is sorted.
- Current FSM state is exported on `state_out` for debug.

---
 rtl/bubble_sorter_pkg.sv | 26 ++
 rtl/sort_ram.sv | 27 ++
 rtl/bubble_sorter.sv | 147 ++++++++++++++
 tb/tb_bubble_sorter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bubble_sorter_pkg.sv
// Shared definitions for the bubble sorter: default sizing, FSM state codes
// and a small helper used to recognise the RAM write-back states.
package bubble_sorter_pkg;

    localparam int N_DEFAULT     = 8;
    localparam int WIDTH_DEFAULT = 8;

    typedef logic [3:0] state_t;

    // State codes are fixed because they are exported on the debug port.
    localparam state_t S_IDLE    = 4'd0;
    localparam state_t S_INIT    = 4'd1;
    localparam state_t S_LOAD_A  = 4'd2;
    localparam state_t S_LOAD_B  = 4'd3;
    localparam state_t S_COMPARE = 4'd4;
    localparam state_t S_WRITE_A = 4'd5;
    localparam state_t S_WRITE_B = 4'd6;
    localparam state_t S_INC_J   = 4'd7;
    localparam state_t S_INC_I   = 4'd8;
    localparam state_t S_DONE    = 4'd9;

    function automatic logic is_write_state(input state_t s);
        return (s == S_WRITE_A) || (s == S_WRITE_B);
    endfunction

endpackage

// File: rtl/sort_ram.sv
// Array storage for the sorter: combinational read, synchronous write.
// Deliberately has no reset so that preloaded contents survive rst_n.
module sort_ram #(
    parameter int N     = 8,
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] ram [0:N-1];

    assign rd_data = ram[rd_addr];

    // Single write port; the new value is seen by reads on the following cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            ram[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/bubble_sorter.sv
// Sequential in-place ascending bubble sort over an internal RAM.
// One comparison costs LOAD_A, LOAD_B, COMPARE, INC_J plus two write cycles
// when the pair is swapped; each pass ends with one INC_I cycle.
module bubble_sorter
    import bubble_sorter_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int AW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       complete,
    output logic [3:0] state_out
);

    // Index of the last pass and, for pass 0, of the last pair start.
    localparam int          LAST_INT = (N >= 2) ? (N - 2) : 0;
    localparam logic [AW:0] LAST     = LAST_INT[AW:0];

    state_t           state;
    state_t           state_next;
    logic [AW-1:0]    i;
    logic [AW-1:0]    j;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    logic [AW:0]      j_last;
    logic             j_at_end;
    logic             i_at_end;

    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             we;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    // The inner loop shrinks by one each pass because the tail is already in place.
    assign j_last   = LAST - {1'b0, i};
    assign j_at_end = ({1'b0, j} == j_last);
    assign i_at_end = ({1'b0, i} == LAST);

    // Next-state decision; unused codes fall back to IDLE.
    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE:    state_next = start ? S_INIT : S_IDLE;
            S_INIT:    state_next = (N < 2) ? S_DONE : S_LOAD_A;
            S_LOAD_A:  state_next = S_LOAD_B;
            S_LOAD_B:  state_next = S_COMPARE;
            S_COMPARE: state_next = (a > b) ? S_WRITE_A : S_INC_J;
            S_WRITE_A: state_next = S_WRITE_B;
            S_WRITE_B: state_next = S_INC_J;
            S_INC_J:   state_next = j_at_end ? S_INC_I : S_LOAD_A;
            S_INC_I:   state_next = i_at_end ? S_DONE : S_LOAD_A;
            S_DONE:    state_next = start ? S_DONE : S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // State register; reset aborts any sort in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pass counter i and pair index j.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i <= '0;
            j <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    i <= '0;
                    j <= '0;
                end
                S_INC_J: begin
                    if (!j_at_end) begin
                        j <= j + AW'(1);
                    end
                end
                S_INC_I: begin
                    if (!i_at_end) begin
                        i <= i + AW'(1);
                        j <= '0;
                    end
                end
                default: begin
                    i <= i;
                    j <= j;
                end
            endcase
        end
    end

    // Operand registers capture the pair under comparison.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a <= '0;
            b <= '0;
        end else begin
            if (state == S_LOAD_A) begin
                a <= rd_data;
            end
            if (state == S_LOAD_B) begin
                b <= rd_data;
            end
        end
    end

    // RAM port control: read j then j+1, swap writes B to j and A to j+1.
    always_comb begin
        rd_addr = j;
        wr_addr = j;
        wr_data = b;
        we      = is_write_state(state);
        if (state == S_LOAD_B) begin
            rd_addr = j + AW'(1);
        end
        if (state == S_WRITE_B) begin
            wr_addr = j + AW'(1);
            wr_data = a;
        end
    end

    assign complete  = (state == S_DONE);
    assign state_out = state;

    sort_ram #(
        .N     (N),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) MEM (
        .clk     (clk),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

endmodule

// File: tb/tb_bubble_sorter.sv
// Bench for bubble_sorter: directed and random arrays checked against a
// sorted-queue model and a cycle count derived from the inversion count.
module tb_bubble_sorter;
    import bubble_sorter_pkg::*;

    localparam int N    = 8;
    localparam int W    = 8;
    localparam int BASE = 1 + (N * (N - 1) / 2) * 4 + (N - 1);

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       complete;
    logic [3:0] state_out;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] stim  [N];
    logic [W-1:0] model [N];

    always #5 clk = ~clk;

    bubble_sorter #(
        .N     (N),
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .complete  (complete),
        .state_out (state_out)
    );

    task automatic preload();
        for (int k = 0; k < N; k++) dut.MEM.ram[k] = stim[k];
    endtask

    // Expected result: the input values in ascending order.
    function automatic void build_model();
        int q[$];
        q = {};
        for (int k = 0; k < N; k++) q.push_back(int'(stim[k]));
        q.sort();
        for (int k = 0; k < N; k++) model[k] = W'(q[k]);
    endfunction

    // Each strictly-out-of-order pair costs exactly one swap.
    function automatic int expected_cycles();
        int inv;
        inv = 0;
        for (int x = 0; x < N; x++)
            for (int y = x + 1; y < N; y++)
                if (stim[x] > stim[y]) inv++;
        return BASE + 2 * inv;
    endfunction

    // Raise start from IDLE and count cycles from INIT to DONE (-1 on timeout).
    task automatic run_sort(output int cycles, output bit saw_write);
        bit found;
        cycles    = -1;
        saw_write = 1'b0;
        found     = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (state_out == S_INIT) found = 1'b1;
        end
        if (!found) return;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (state_out == S_WRITE_A || state_out == S_WRITE_B) saw_write = 1'b1;
            if (state_out == S_DONE) begin
                cycles = n + 1;
                return;
            end
        end
    endtask

    task automatic drop_start();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (state_out !== S_IDLE) begin
            failures++;
            $display("[TB] FAIL reset_state: got %0d expected %0d", state_out, S_IDLE);
        end
        checks++;
        if (complete !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_complete: got %0b expected 0", complete);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reversed();
        int  cyc;
        bit  sw;
        for (int k = 0; k < N; k++) stim[k] = W'(N - 1 - k);
        preload();
        run_sort(cyc, sw);
        checks++;
        if (cyc !== 176) begin
            failures++;
            $display("[TB] FAIL reversed_cycles: got %0d expected 176", cyc);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (dut.MEM.ram[k] !== W'(k)) begin
                failures++;
                $display("[TB] FAIL reversed_ram[%0d]: got %h expected %h", k, dut.MEM.ram[k], W'(k));
            end
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (complete !== 1'b1 || state_out !== S_DONE) begin
                failures++;
                $display("[TB] FAIL hold_done: got complete=%0b state=%0d expected complete=1 state=9", complete, state_out);
            end
        end
        drop_start();
        checks++;
        if (state_out !== S_IDLE || complete !== 1'b0) begin
            failures++;
            $display("[TB] FAIL release_idle: got complete=%0b state=%0d expected complete=0 state=0", complete, state_out);
        end
    endtask

    task automatic test_sorted();
        int cyc;
        bit sw;
        for (int k = 0; k < N; k++) stim[k] = W'(k);
        preload();
        run_sort(cyc, sw);
        checks++;
        if (cyc !== 120) begin
            failures++;
            $display("[TB] FAIL sorted_cycles: got %0d expected 120", cyc);
        end
        checks++;
        if (sw !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sorted_no_write: got %0b expected 0", sw);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (dut.MEM.ram[k] !== stim[k]) begin
                failures++;
                $display("[TB] FAIL sorted_ram[%0d]: got %h expected %h", k, dut.MEM.ram[k], stim[k]);
            end
        end
        drop_start();
    endtask

    task automatic test_extremes();
        int           cyc;
        bit           sw;
        logic [W-1:0] want [N];
        stim = '{8'h80, 8'hFF, 8'h00, 8'h80, 8'h01, 8'hFF, 8'h00, 8'h7F};
        want = '{8'h00, 8'h00, 8'h01, 8'h7F, 8'h80, 8'h80, 8'hFF, 8'hFF};
        preload();
        run_sort(cyc, sw);
        checks++;
        if (cyc !== expected_cycles()) begin
            failures++;
            $display("[TB] FAIL extremes_cycles: got %0d expected %0d", cyc, expected_cycles());
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (dut.MEM.ram[k] !== want[k]) begin
                failures++;
                $display("[TB] FAIL extremes_ram[%0d]: got %h expected %h", k, dut.MEM.ram[k], want[k]);
            end
        end
        drop_start();
    endtask

    task automatic test_all_equal();
        int cyc;
        bit sw;
        for (int k = 0; k < N; k++) stim[k] = 8'hAA;
        preload();
        run_sort(cyc, sw);
        checks++;
        if (cyc !== 120 || sw !== 1'b0) begin
            failures++;
            $display("[TB] FAIL equal_timing: got cycles=%0d write=%0b expected cycles=120 write=0", cyc, sw);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (dut.MEM.ram[k] !== 8'hAA) begin
                failures++;
                $display("[TB] FAIL equal_ram[%0d]: got %h expected aa", k, dut.MEM.ram[k]);
            end
        end
        drop_start();
    endtask

    task automatic test_reset_mid_sort();
        int cyc;
        bit sw;
        bit found;
        int q[$];
        for (int k = 0; k < N; k++) stim[k] = W'(N - 1 - k);
        build_model();
        preload();
        found = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (state_out == S_INIT) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("[TB] FAIL midreset_init: got state=%0d expected 1", state_out);
        end
        repeat (50) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (state_out !== S_IDLE || complete !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_async: got complete=%0b state=%0d expected complete=0 state=0", complete, state_out);
        end
        q = {};
        for (int k = 0; k < N; k++) q.push_back(int'(dut.MEM.ram[k]));
        q.sort();
        for (int k = 0; k < N; k++) begin
            checks++;
            if (W'(q[k]) !== model[k]) begin
                failures++;
                $display("[TB] FAIL midreset_perm[%0d]: got %h expected %h", k, W'(q[k]), model[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++) stim[k] = dut.MEM.ram[k];
        run_sort(cyc, sw);
        checks++;
        if (cyc !== expected_cycles()) begin
            failures++;
            $display("[TB] FAIL midreset_cycles: got %0d expected %0d", cyc, expected_cycles());
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (dut.MEM.ram[k] !== W'(k)) begin
                failures++;
                $display("[TB] FAIL midreset_ram[%0d]: got %h expected %h", k, dut.MEM.ram[k], W'(k));
            end
        end
        drop_start();
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit sw;
        for (int k = 0; k < N; k++) stim[k] = W'(k * 3);
        preload();
        for (int r = 0; r < 2; r++) begin
            run_sort(cyc, sw);
            checks++;
            if (cyc !== 120) begin
                failures++;
                $display("[TB] FAIL rerun_cycles[%0d]: got %0d expected 120", r, cyc);
            end
            drop_start();
            checks++;
            if (state_out !== S_IDLE || complete !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rerun_idle[%0d]: got complete=%0b state=%0d expected complete=0 state=0", r, complete, state_out);
            end
        end
    endtask

    task automatic test_random();
        int cyc;
        bit sw;
        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < N; k++)
                stim[k] = (it % 2 == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 3));
            build_model();
            preload();
            run_sort(cyc, sw);
            checks++;
            if (cyc !== expected_cycles()) begin
                failures++;
                $display("[TB] FAIL random_cycles[%0d]: got %0d expected %0d", it, cyc, expected_cycles());
            end
            for (int k = 0; k < N; k++) begin
                checks++;
                if (dut.MEM.ram[k] !== model[k]) begin
                    failures++;
                    $display("[TB] FAIL random_ram[%0d][%0d]: got %h expected %h", it, k, dut.MEM.ram[k], model[k]);
                end
            end
            drop_start();
        end
    endtask

    initial begin
        $display("[TB] bubble_sorter bench starting");
        test_reset();
        test_reversed();
        test_sorted();
        test_extremes();
        test_all_equal();
        test_reset_mid_sort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
